// File: rtl/mod_updown_counter.sv
// Synchronous modulo-N up/down counter with parallel load, a terminal-count pulse
// and a saturating wrap-event counter. Every output is registered.
module mod_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter int WRAP_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              up_dn,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              load_err,
   output logic [WRAP_W-1:0] wraps
);

   // The range check needs WIDTH+1 bits so that MODULUS == 2**WIDTH stays representable.
   localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

   logic             at_top, at_zero, in_range, wrap;
   logic [WIDTH-1:0] count_nxt;

   always_comb begin
      at_top    = (count == TOP);
      at_zero   = (count == '0);
      in_range  = ({1'b0, load_val} < MOD_X);
      wrap      = en && !load && (up_dn ? at_top : at_zero);
      count_nxt = count;
      if (load)
         count_nxt = in_range ? load_val : TOP;
      else if (en) begin
         if (up_dn)
            count_nxt = at_top ? '0 : count + 1'b1;
         else
            count_nxt = at_zero ? TOP : count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         tc       <= 1'b0;
         load_err <= 1'b0;
         wraps    <= '0;
      end else begin
         count    <= count_nxt;
         tc       <= wrap;
         load_err <= load && !in_range;
         if (wrap && wraps != '1)
            wraps <= wraps + 1'b1;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed vector table on a decade counter, a full-range
// saturation run, then random stimulus against an arithmetic reference model.
module tb_mod_updown_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
   logic [3:0] lv = '0;

   logic [3:0] c10, c16;
   logic [0:0] c2;
   logic       t10, t16, t2, e10, e16, e2;
   logic [7:0] w10;
   logic [1:0] w16;
   logic [2:0] w2;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP_W(8)) d10 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv),
      .count(c10), .tc(t10), .load_err(e10), .wraps(w10));
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .WRAP_W(2)) d16 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv),
      .count(c16), .tc(t16), .load_err(e16), .wraps(w16));
   mod_updown_counter #(.WIDTH(1), .MODULUS(2), .WRAP_W(3)) d2 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[0:0]),
      .count(c2), .tc(t2), .load_err(e2), .wraps(w2));

   int nvec = 0, nerr = 0;

   // reference model state per instance: 0 -> d10, 1 -> d16, 2 -> d2
   int mods[3] = '{10, 16, 2};
   int wmax[3] = '{255, 3, 7};
   int lvm[3]  = '{16, 16, 2};
   int mc[3], mt[3], me[3], mw[3];

   typedef struct {
      bit rst, en, up, ld;
      int lv;
      int ec;
      bit et, ee;
      int ew;
   } vec_t;
   vec_t tbl[$];

   function automatic void chk(string name, int act, int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void model_step(bit r, bit e, bit u, bit l, int v);
      for (int i = 0; i < 3; i++) begin
         int raw, val;
         if (r) begin
            mc[i] = 0; mt[i] = 0; me[i] = 0; mw[i] = 0;
         end else if (l) begin
            val   = v % lvm[i];
            mt[i] = 0;
            me[i] = (val >= mods[i]);
            mc[i] = me[i] ? mods[i] - 1 : val;
         end else if (e) begin
            raw   = u ? mc[i] + 1 : mc[i] - 1;
            mt[i] = (raw < 0 || raw >= mods[i]);
            mc[i] = (raw + mods[i]) % mods[i];
            me[i] = 0;
            if (mt[i] != 0 && mw[i] < wmax[i]) mw[i]++;
         end else begin
            mt[i] = 0; me[i] = 0;
         end
      end
   endfunction

   function automatic void model_cmp();
      int ac[3], at[3], ae[3], aw[3];
      ac = '{int'(c10), int'(c16), int'(c2)};
      at = '{int'(t10), int'(t16), int'(t2)};
      ae = '{int'(e10), int'(e16), int'(e2)};
      aw = '{int'(w10), int'(w16), int'(w2)};
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("m%0d.count", mods[i]), ac[i], mc[i]);
         chk($sformatf("m%0d.tc", mods[i]), at[i], mt[i]);
         chk($sformatf("m%0d.load_err", mods[i]), ae[i], me[i]);
         chk($sformatf("m%0d.wraps", mods[i]), aw[i], mw[i]);
      end
   endfunction

   task automatic step(bit r, bit e, bit u, bit l, int v);
      @(negedge clk);
      reset = r; en = e; up_dn = u; load = l; lv = 4'(v);
      @(posedge clk);
      #1;
      model_step(r, e, u, l, v);
      model_cmp();
   endtask

   initial begin
      int pulses;

      // 1: decade count up
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
      for (int i = 1; i <= 12; i++)
         tbl.push_back('{0, 1, 1, 0, 0, i % 10, (i == 10), 0, (i >= 10)});
      // 2: down wrap
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 0, 0, 9, 1, 0, 1});
      tbl.push_back('{0, 1, 0, 0, 0, 8, 0, 0, 1});
      tbl.push_back('{0, 1, 0, 0, 0, 7, 0, 0, 1});
      // 3: load and out-of-range load
      tbl.push_back('{0, 1, 1, 1, 7, 7, 0, 0, 1});
      tbl.push_back('{0, 1, 1, 1, 12, 9, 0, 1, 1});
      tbl.push_back('{0, 0, 1, 0, 0, 9, 0, 0, 1});
      // 4: priority and hold
      tbl.push_back('{0, 1, 1, 1, 3, 3, 0, 0, 1});
      for (int i = 0; i < 5; i++)
         tbl.push_back('{0, 0, 1, 0, 0, 3, 0, 0, 1});
      tbl.push_back('{1, 1, 1, 1, 5, 0, 0, 0, 0});
      // 6: mid-count reset swallows a pending wrap
      tbl.push_back('{0, 0, 1, 1, 9, 9, 0, 0, 0});
      tbl.push_back('{0, 1, 1, 0, 0, 0, 1, 0, 1});
      tbl.push_back('{0, 0, 1, 1, 9, 9, 0, 0, 1});
      tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0, 0});
      tbl.push_back('{0, 1, 1, 0, 0, 2, 0, 0, 0});

      foreach (tbl[k]) begin
         step(tbl[k].rst, tbl[k].en, tbl[k].up, tbl[k].ld, tbl[k].lv);
         chk($sformatf("vec%0d.count", k), int'(c10), tbl[k].ec);
         chk($sformatf("vec%0d.tc", k), int'(t10), int'(tbl[k].et));
         chk($sformatf("vec%0d.load_err", k), int'(e10), int'(tbl[k].ee));
         chk($sformatf("vec%0d.wraps", k), int'(w10), tbl[k].ew);
      end

      // 5: full-range binary, 2-bit wrap counter saturates at 3
      step(1, 0, 0, 0, 0);
      pulses = 0;
      for (int i = 1; i <= 70; i++) begin
         step(0, 1, 1, 0, 0);
         pulses += int'(t16);
         if (i == 16 || i == 32 || i == 48)
            chk($sformatf("full.wraps@%0d", i), int'(w16), i / 16);
      end
      chk("full.tc_pulses", pulses, 4);
      chk("full.wraps_sat", int'(w16), 3);
      chk("full.load_err_range", int'(e16), 0);
      step(0, 1, 1, 1, 15);
      chk("full.load15_no_err", int'(e16), 0);

      // random stimulus against the model
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
